// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: two-master, one-slave round-robin arbiter for the Avalon-style
// memory bus. Master 0 is the CPU port, master 1 a secondary requester (loader/DMA).
// The owner keeps the bus until its transfer completes. Back-to-back transfers from
// the same owner are allowed. A sticky flag marks any transfer that stalls too long.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   m0_* / m1_*           master request buses in; readdata/waitrequest out
//   s_*                   single slave port (address/read/write/writedata/byteenable
//                         out; readdata/waitrequest in)
//   grant                 one-hot owner {m1,m0}; 2'b00 when idle (registered)
//   bus_timeout           sticky stall-timeout flag (registered)
module mips_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BE_W           = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_waitrequest,
  output logic [1:0]        grant,
  output logic              bus_timeout
);

  localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_d;
  logic             last_q, last_d;   // 1: master 1 completed most recently
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;
  logic             req0, req1, done;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Next owner: ties from idle go to the master that did not complete last;
  // on completion a waiting peer takes over with no idle gap.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1)  state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (req0)     state_d = ST_OWN0;
        else if (req1)     state_d = ST_OWN1;
      end
      ST_OWN0: begin
        done = req0 & ~s_waitrequest;
        if (done) begin
          last_d  = 1'b0;
          state_d = req1 ? ST_OWN1 : ST_OWN0;
        end else if (!req0) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        done = req1 & ~s_waitrequest;
        if (done) begin
          last_d  = 1'b1;
          state_d = req0 ? ST_OWN0 : ST_OWN1;
        end else if (!req1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stall counter restarts with every transfer; the flag latches when it saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE || done || state_d != state_q) begin
      cnt_d = '0;
    end else if (s_waitrequest && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    timeout_d = bus_timeout | (cnt_d == CNT_MAX);
  end

  // Grant encoding of the next owner.
  always_comb begin
    grant_d = 2'b00;
    case (state_d)
      ST_OWN0: grant_d = 2'b01;
      ST_OWN1: grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // All arbiter state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant       <= 2'b00;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      bus_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant       <= grant_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      bus_timeout <= timeout_d;
    end
  end

  // Slave-side mux: owner passes straight through, everyone else stalls.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    unique case (state_q)
      ST_OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      ST_OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: begin
      end
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule
